// File: rtl/ebpf_rb_pkg.sv
// rtl/ebpf_rb_pkg.sv - shared constants and helpers for the eBPF register bank write scheduler.
package ebpf_rb_pkg;

  localparam int NUM_REGS = 11;
  localparam int ADDR_W   = 4;
  localparam int NUM_SRC  = 4;

  // Source index doubles as the bank's dst_in_slc encoding.
  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_PKT = 2'd1,
    SRC_IMM = 2'd2,
    SRC_RAM = 2'd3
  } wb_src_e;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return a < ADDR_W'(NUM_REGS);
  endfunction

  // Out-of-range addresses decode to all-zero, so they never touch the scoreboard.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] a);
    return NUM_REGS'(1) << a;
  endfunction

endpackage

// File: rtl/wb_rr_arb.sv
// rtl/wb_rr_arb.sv - 4-way writeback arbiter; RR_ARB_EN selects round-robin, else fixed RAM>PKT>ALU>IMM.
module wb_rr_arb
  import ebpf_rb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] gnt,
  output wb_src_e            gnt_idx
);

`ifdef RR_ARB_EN
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] cand;
  logic       found;

  // Scan starting at the pointer; the first requester in that rotation wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = SRC_ALU;
    found   = 1'b0;
    cand    = ptr_q;
    ptr_d   = ptr_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = wb_src_e'(cand);
      end
    end
    if (found) begin
      ptr_d = gnt_idx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= SRC_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk | rst;

  always_comb begin
    gnt     = '0;
    gnt_idx = SRC_ALU;
    if (req[SRC_RAM]) begin
      gnt[SRC_RAM] = 1'b1;
      gnt_idx      = SRC_RAM;
    end else if (req[SRC_PKT]) begin
      gnt[SRC_PKT] = 1'b1;
      gnt_idx      = SRC_PKT;
    end else if (req[SRC_ALU]) begin
      gnt[SRC_ALU] = 1'b1;
      gnt_idx      = SRC_ALU;
    end else if (req[SRC_IMM]) begin
      gnt[SRC_IMM] = 1'b1;
      gnt_idx      = SRC_IMM;
    end
  end
`endif

endmodule

// File: rtl/reg_wb_sched.sv
// rtl/reg_wb_sched.sv - register bank write-port scheduler with load scoreboard; arbitration style set by RR_ARB_EN.
module reg_wb_sched
  import ebpf_rb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_req,
  input  logic [ADDR_W-1:0]         rd_src_addr,
  input  logic [ADDR_W-1:0]         rd_dst_addr,
  input  logic                      rd_zeroout,
  output logic                      rd_stall,
  input  logic [NUM_SRC-1:0]        wb_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] wb_addr,
  input  logic [NUM_SRC-1:0]        wb_zeroout,
  output logic [NUM_SRC-1:0]        wb_ready,
  input  logic                      ld_issue,
  input  logic [ADDR_W-1:0]         ld_addr,
  output logic                      ld_stall,
  output logic                      rb_en,
  output logic                      rb_rw,
  output logic [ADDR_W-1:0]         rb_src_addr,
  output logic [ADDR_W-1:0]         rb_dst_addr,
  output logic [1:0]                rb_dst_in_slc,
  output logic                      rb_zeroout,
  output logic                      err_badaddr
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [NUM_REGS-1:0] sb_q, sb_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                err_q, err_d;

  logic [NUM_SRC-1:0]  arb_req, gnt;
  wb_src_e             gnt_idx;
  logic [ADDR_W-1:0]   wr_addr;
  logic                starved, wr, wr_bad, hazard;
  logic [NUM_REGS-1:0] ld_dec;
  logic                ld_bad, ld_busy;

  // A starved cycle and reset both hide every request from the arbiter.
  assign starved = (starve_q == CNT_W'(STARVE_MAX));
  assign arb_req = (rst && !starved) ? wb_valid : '0;

  wb_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    wr_addr = wb_addr[0 +: ADDR_W];
    case (gnt_idx)
      SRC_PKT: wr_addr = wb_addr[ADDR_W +: ADDR_W];
      SRC_IMM: wr_addr = wb_addr[2*ADDR_W +: ADDR_W];
      SRC_RAM: wr_addr = wb_addr[3*ADDR_W +: ADDR_W];
      default: wr_addr = wb_addr[0 +: ADDR_W];
    endcase
  end

  always_comb begin
    wr      = |gnt;
    wr_bad  = !addr_ok(wr_addr);
    hazard  = rd_req && |(sb_q & (reg_onehot(rd_src_addr) | reg_onehot(rd_dst_addr)));
    ld_dec  = reg_onehot(ld_addr);
    ld_bad  = !addr_ok(ld_addr);
    ld_busy = |(sb_q & ld_dec);

    wb_ready      = gnt;
    rb_en         = rst && (wr || (rd_req && !hazard));
    rb_rw         = wr && !wr_bad;
    rd_stall      = !rst || (rd_req && (wr || hazard));
    ld_stall      = !rst || (ld_issue && ld_busy);
    rb_src_addr   = rd_src_addr;
    rb_dst_addr   = wr ? wr_addr : rd_dst_addr;
    rb_dst_in_slc = gnt_idx;
    rb_zeroout    = wr ? wb_zeroout[gnt_idx] : rd_zeroout;
    err_badaddr   = err_q;
  end

  // Clear from a load writeback is applied first so a same-cycle issue wins.
  always_comb begin
    sb_d = sb_q;
    if (wr && !wr_bad && (gnt_idx == SRC_PKT || gnt_idx == SRC_RAM)) begin
      sb_d = sb_d & ~reg_onehot(wr_addr);
    end
    if (ld_issue && !ld_busy) begin
      sb_d = sb_d | ld_dec;
    end

    starve_d = starve_q;
    if (starved) begin
      starve_d = '0;
    end else if (rd_req && wr) begin
      starve_d = starve_q + CNT_W'(1);
    end else if (rd_req) begin
      starve_d = '0;
    end

    err_d = err_q | (wr && wr_bad) | (ld_issue && ld_bad);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sb_q     <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      sb_q     <= sb_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_reg_wb_sched.sv
// tb/tb_reg_wb_sched.sv - randomized model-checked bench for reg_wb_sched (both RR_ARB_EN builds).
module tb_reg_wb_sched;

  localparam int NREG = 11;
  localparam int SMAX = 4;

  logic        clk;
  logic        rst;
  logic        rd_req;
  logic [3:0]  rd_src_addr, rd_dst_addr;
  logic        rd_zeroout;
  logic        rd_stall;
  logic [3:0]  wb_valid;
  logic [15:0] wb_addr;
  logic [3:0]  wb_zeroout;
  logic [3:0]  wb_ready;
  logic        ld_issue;
  logic [3:0]  ld_addr;
  logic        ld_stall;
  logic        rb_en, rb_rw;
  logic [3:0]  rb_src_addr, rb_dst_addr;
  logic [1:0]  rb_dst_in_slc;
  logic        rb_zeroout;
  logic        err_badaddr;

  reg_wb_sched #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_src_addr(rd_src_addr), .rd_dst_addr(rd_dst_addr),
    .rd_zeroout(rd_zeroout), .rd_stall(rd_stall),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_zeroout(wb_zeroout), .wb_ready(wb_ready),
    .ld_issue(ld_issue), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .rb_en(rb_en), .rb_rw(rb_rw), .rb_src_addr(rb_src_addr), .rb_dst_addr(rb_dst_addr),
    .rb_dst_in_slc(rb_dst_in_slc), .rb_zeroout(rb_zeroout), .err_badaddr(err_badaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Reference state: pending-load set, starvation run length, sticky error, RR pointer.
  bit m_pend[16];
  int m_starve = 0;
  bit m_err    = 1'b0;
  bit m_known  = 1'b0;
  int m_ptr    = 0;
  int prio[4]  = '{3, 1, 0, 2};

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h want %0h", nm, cyc, act, exp);
  endtask

  // Apply one cycle of inputs, check every output at the falling edge, then advance the model.
  task automatic drive(input bit r, input bit rq, input int rs, input int rdd, input bit rz,
                       input bit [3:0] v, input bit [15:0] a, input bit [3:0] z,
                       input bit li, input int la);
    int g, wa, s;
    bit wr, wbad, haz, lbad, lbusy;
    rst = r; rd_req = rq; rd_src_addr = 4'(rs); rd_dst_addr = 4'(rdd); rd_zeroout = rz;
    wb_valid = v; wb_addr = a; wb_zeroout = z; ld_issue = li; ld_addr = 4'(la);
    g = -1;
    if (r && m_starve != SMAX) begin
      for (int k = 0; k < 4; k++) begin
`ifdef RR_ARB_EN
        s = (m_ptr + k) % 4;
`else
        s = prio[k];
`endif
        if (g < 0 && v[s]) g = s;
      end
    end
    wr    = (g >= 0);
    wa    = wr ? int'((a >> (4 * g)) & 16'hF) : 0;
    wbad  = wr && (wa >= NREG);
    haz   = rq && ((rs < NREG && m_pend[rs]) || (rdd < NREG && m_pend[rdd]));
    lbad  = (la >= NREG);
    lbusy = !lbad && m_pend[la];
    @(negedge clk);
    chk("wb_ready", 16'(wb_ready), wr ? 16'(1 << g) : 16'h0);
    chk("rb_en", 16'(rb_en), 16'(r && (wr || (rq && !haz))));
    chk("rb_rw", 16'(rb_rw), 16'(wr && !wbad));
    chk("rd_stall", 16'(rd_stall), 16'(!r || (rq && (wr || haz))));
    chk("ld_stall", 16'(ld_stall), 16'(!r || (li && lbusy)));
    if (m_known) chk("err_badaddr", 16'(err_badaddr), 16'(m_err));
    if (r) begin
      chk("rb_dst_addr", 16'(rb_dst_addr), wr ? 16'(wa) : 16'(rdd));
      chk("rb_dst_in_slc", 16'(rb_dst_in_slc), wr ? 16'(g) : 16'h0);
      chk("rb_zeroout", 16'(rb_zeroout), wr ? 16'(z[g]) : 16'(rz));
      if (!wr) chk("rb_src_addr", 16'(rb_src_addr), 16'(rs));
    end
    if (!r) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_starve = 0; m_err = 1'b0; m_ptr = 0; m_known = 1'b1;
    end else begin
      if (wr && !wbad && (g == 1 || g == 3)) m_pend[wa] = 1'b0;
      if (li && !lbad && !lbusy) m_pend[la] = 1'b1;
      if (wbad || (li && lbad)) m_err = 1'b1;
      if (m_starve == SMAX) m_starve = 0;
      else if (rq && wr) m_starve++;
      else if (rq) m_starve = 0;
      if (wr) m_ptr = (g + 1) % 4;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input bit r);
    drive(r, 0, 0, 0, 0, 4'b0, 16'h0, 4'b0, 0, 0);
    adv();
  endtask

  function automatic int rand_addr();
    return ($urandom_range(0, 15) == 0) ? int'($urandom_range(11, 15)) : int'($urandom_range(0, 10));
  endfunction

  initial begin
    bit [3:0] v;
    bit [15:0] a;
    int        exp_rdy[4];
    int        exp_slc[4];
    int        exp_dst[4];
    rst = 1'b0; rd_req = 0; rd_src_addr = 0; rd_dst_addr = 0; rd_zeroout = 0;
    wb_valid = 0; wb_addr = 0; wb_zeroout = 0; ld_issue = 0; ld_addr = 0;
    @(posedge clk); #1;

    // Reset holds the forced output values.
    drive(0, 1, 0, 0, 0, 4'hF, 16'h4321, 4'h0, 1, 2);
    chk("lit_rst_ready", 16'(wb_ready), 16'h0);
    chk("lit_rst_rdstall", 16'(rd_stall), 16'h1);
    chk("lit_rst_ldstall", 16'(ld_stall), 16'h1);
    chk("lit_rst_rben", 16'(rb_en), 16'h0);
    adv();
    idle(1);
    chk("lit_rst_err", 16'(err_badaddr), 16'h0);

    // Four sources queued; each drops its request once granted.
    v = 4'hF;
    a = {4'd4, 4'd3, 4'd2, 4'd1};
`ifdef RR_ARB_EN
    v = 4'b0101;
    exp_rdy = '{1, 4, 1, 4}; exp_slc = '{0, 2, 0, 2}; exp_dst = '{1, 3, 1, 3};
`else
    exp_rdy = '{8, 2, 1, 4}; exp_slc = '{3, 1, 0, 2}; exp_dst = '{4, 2, 1, 3};
`endif
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, v, a, 4'b0, 0, 0);
      chk("lit_arb_ready", 16'(wb_ready), 16'(exp_rdy[i]));
      chk("lit_arb_slc", 16'(rb_dst_in_slc), 16'(exp_slc[i]));
      chk("lit_arb_dst", 16'(rb_dst_addr), 16'(exp_dst[i]));
      adv();
`ifndef RR_ARB_EN
      v = v & ~4'(exp_rdy[i]);
`endif
    end

    // Load to R5 blocks decode until the RAM writeback returns.
    drive(1, 0, 0, 0, 0, 4'b0, 16'h0, 4'b0, 1, 5);
    chk("lit_ld_first", 16'(ld_stall), 16'h0);
    adv();
    drive(1, 1, 5, 0, 0, 4'b0, 16'h0, 4'b0, 1, 5);
    chk("lit_haz_stall", 16'(rd_stall), 16'h1);
    chk("lit_haz_rben", 16'(rb_en), 16'h0);
    chk("lit_ld_again", 16'(ld_stall), 16'h1);
    adv();
    drive(1, 1, 5, 0, 0, 4'b1000, 16'h5000, 4'b0, 0, 0);
    chk("lit_ram_wb", 16'(wb_ready), 16'h8);
    chk("lit_ram_rw", 16'(rb_rw), 16'h1);
    adv();
    drive(1, 1, 5, 0, 0, 4'b0, 16'h0, 4'b0, 0, 0);
    chk("lit_haz_clear", 16'(rd_stall), 16'h0);
    chk("lit_haz_rben1", 16'(rb_en), 16'h1);
    adv();

    // Continuous ALU traffic with decode waiting: 4 grants then one read slot.
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, 0, 0, 4'b0001, 16'h0006, 4'b0, 0, 0);
      chk("lit_starve_ready", 16'(wb_ready), (i % 5 == 4) ? 16'h0 : 16'h1);
      chk("lit_starve_stall", 16'(rd_stall), (i % 5 == 4) ? 16'h0 : 16'h1);
      adv();
    end

    // Out-of-range writeback target.
    drive(1, 0, 0, 0, 0, 4'b0001, 16'h000C, 4'b0, 0, 0);
    chk("lit_bad_ready", 16'(wb_ready), 16'h1);
    chk("lit_bad_rw", 16'(rb_rw), 16'h0);
    adv();
    for (int i = 0; i < 2; i++) begin
      idle(1);
      chk("lit_bad_sticky", 16'(err_badaddr), 16'h1);
    end

    // Reset in the middle of two pending loads.
    drive(1, 0, 0, 0, 0, 4'b0, 16'h0, 4'b0, 1, 3); adv();
    drive(1, 0, 0, 0, 0, 4'b0, 16'h0, 4'b0, 1, 7); adv();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 3, 7, 0, 4'hF, 16'h1234, 4'b0, 0, 0);
      chk("lit_mid_ready", 16'(wb_ready), 16'h0);
      chk("lit_mid_stall", 16'(rd_stall), 16'h1);
      adv();
    end
    drive(1, 1, 3, 7, 0, 4'b0, 16'h0, 4'b0, 0, 0);
    chk("lit_mid_sbclr", 16'(rd_stall), 16'h0);
    chk("lit_mid_errclr", 16'(err_badaddr), 16'h0);
    adv();

    for (int i = 0; i < 3000; i++) begin
      bit [15:0] ra;
      for (int k = 0; k < 4; k++) ra[4*k +: 4] = 4'(rand_addr());
      drive($urandom_range(0, 99) != 0, 1'($urandom), rand_addr(), rand_addr(), 1'($urandom),
            4'($urandom & $urandom), ra, 4'($urandom), $urandom_range(0, 3) == 0, rand_addr());
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_wb_sched.md
Name: reg_wb_sched

Overview:
- Write-port scheduler and hazard controller in front of the 11-entry eBPF register bank.
- Arbitrates four writeback sources onto the bank's single write port: ALU, packet buffer, immediate, RAM.
- Shares the bank's dst address lines between decode reads and writeback.
- Tracks in-flight multi-cycle loads in a scoreboard and stalls decode on read-after-load hazards.

Parameters:
- NUM_REGS, 11: number of architectural registers, R0..R10.
- STARVE_MAX, 4: maximum number of consecutive cycles decode can be stalled by writeback before it is given one cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- rd_req  in  1  decode wants to read the bank this cycle.
- rd_src_addr  in  4  decode source register.
- rd_dst_addr  in  4  decode destination register (read).
- rd_zeroout  in  1  decode 32-bit read mode.
- rd_stall  out  1  decode must hold this cycle.
- wb_valid  in  4  writeback request, one bit per source: [0]=ALU, [1]=PKT, [2]=IMM, [3]=RAM.
- wb_addr  in  16  packed target register, 4 bits per source, source i at [4i+3:4i].
- wb_zeroout  in  4  per-source 32-bit write mode.
- wb_ready  out  4  grant, one-hot or zero.
- ld_issue  in  1  PKT or RAM load launched.
- ld_addr  in  4  load target register.
- ld_stall  out  1  load issue refused because the target is already pending.
- rb_en  out  1  register bank enable.
- rb_rw  out  1  register bank write strobe.
- rb_src_addr  out  4  register bank source address.
- rb_dst_addr  out  4  register bank destination address.
- rb_dst_in_slc  out  2  register bank input select.
- rb_zeroout  out  1  register bank 32-bit mode.
- err_badaddr  out  1  sticky: a request targeted a register >= NUM_REGS.

Behaviour:
- Reset (rst=0 at posedge):
  - Scoreboard, starve counter and err_badaddr go to 0.
  - RR pointer goes to ALU.
  - While rst=0, combinational outputs are forced: wb_ready=0, rb_en=0, rb_rw=0, rd_stall=1, ld_stall=1.
- A handshake completes in the same cycle when wb_valid[i] & wb_ready[i].
  - The bank write lands at that posedge.
  - Read-after-write latency is 1 cycle.
- Write cycle (any grant):
  - rb_en=1, rb_rw=1.
  - rb_dst_addr = granted wb_addr.
  - rb_dst_in_slc = granted index (00 ALU, 01 PKT, 10 IMM, 11 RAM).
  - rb_zeroout = granted wb_zeroout.
  - rd_stall=1 whenever rd_req=1, because the dst lines and zeroout are shared.
- Read cycle (no grant):
  - rb_en = rd_req, rb_rw=0.
  - rb_src_addr, rb_dst_addr and rb_zeroout come from the rd_* inputs.
  - rb_dst_in_slc=00.
- Starvation:
  - The counter increments each cycle in which rd_req=1 and a grant occurs.
  - When it reaches STARVE_MAX, that cycle grants nothing (wb_ready=0) and decode reads. The counter clears.
  - The counter also clears on any cycle with rd_req=1 and no grant.
- Scoreboard (NUM_REGS bits):
  - ld_issue sets bit ld_addr, unless that bit is already set. In that case ld_stall=1 and nothing is recorded.
  - A PKT or RAM handshake clears bit wb_addr.
  - If a set and a clear of the same bit happen in the same cycle, the set wins.
- Read hazard:
  - If rd_req=1 and the scoreboard bit of rd_src_addr or rd_dst_addr is set, then rd_stall=1 and rb_en=0.
  - A granted write still proceeds in that cycle.
- Bad address (wb_addr or ld_addr >= NUM_REGS):
  - The request is still granted or consumed.
  - rb_rw=0 for that write, the scoreboard is untouched, and err_badaddr is set until reset.

Optional Feature:
- RR_ARB_EN defined:
  - Round-robin arbitration.
  - Priority starts at the source after the last granted one.
  - The pointer advances only on a handshake.
- RR_ARB_EN undefined:
  - Fixed priority RAM > PKT > ALU > IMM.
  - No pointer state.

Decomposition:
- Package ebpf_rb_pkg holds:
  - NUM_REGS.
  - Source indices SRC_ALU=0, SRC_PKT=1, SRC_IMM=2, SRC_RAM=3, which double as the dst_in_slc encoding.
  - Register address width (4).
- Sub-module wb_rr_arb: 4-way arbiter (request vector -> one-hot grant, plus pointer register). It contains the RR_ARB_EN switch.

Test Plan:
- Fixed priority, no RR: wb_valid=1111 with addrs R1,R2,R3,R4 -> grants RAM, PKT, ALU, IMM in that order over 4 cycles. rb_dst_in_slc=11,01,00,10. Final values land in R4,R2,R1,R3.
- RR_ARB_EN defined: wb_valid=0101 held for 4 cycles -> grants ALU, IMM, ALU, IMM. Pointer returns to ALU after reset.
- Load hazard:
  - ld_issue on R5, then rd_req with rd_src_addr=5 -> rd_stall=1.
  - RAM writeback to R5 -> rd_stall drops on the next cycle and the read returns the new value.
  - A second ld_issue to R5 while pending -> ld_stall=1.
- Starvation: rd_req=1 with ALU writebacks every cycle -> 4 granted cycles, then 1 cycle with wb_ready=0 and rd_stall=0; the pattern repeats.
- Bad address: ALU wb_addr=12 -> wb_ready[0]=1, rb_rw=0, err_badaddr=1 and stays set; rst=0 clears it.
- Mid-operation reset: assert rst=0 with the scoreboard at R3, R7 pending -> next cycle all bits are 0, wb_ready=0 and rd_stall=1 while held.
